// File: rtl/branch_rs_unit.sv
// Branch reservation station with CDB operand wakeup, oldest-ready-first issue, a branch
// comparator and a registered ROB result port. Optional macro: BRA_DISPATCH_BYPASS_EN.
module branch_rs_unit #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int LOCK_W = 5,
    parameter int ROB_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bra_enable,
    output logic              bra_stall,
    input  logic [2:0]        bra_op,
    input  logic [DATA_W-1:0] bra_data1,
    input  logic [LOCK_W-1:0] bra_lock1,
    input  logic [DATA_W-1:0] bra_data2,
    input  logic [LOCK_W-1:0] bra_lock2,
    input  logic [ROB_W-1:0]  bra_rob_index,
    input  logic              bra_pred,
    input  logic [LOCK_W-1:0] cdb_in_index,
    input  logic [DATA_W-1:0] cdb_in_result,
    input  logic              flush,
    output logic              rob_out_valid,
    input  logic              rob_out_ready,
    output logic [ROB_W-1:0]  rob_out_index,
    output logic [1:0]        rob_out_result,
    output logic              rob_out_mispredict
);

    localparam int RANK_W = $clog2(DEPTH);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_BEQ  = 3'd1,
        OP_BNE  = 3'd2,
        OP_BLT  = 3'd3,
        OP_BGE  = 3'd4,
        OP_BLTU = 3'd5,
        OP_BGEU = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [DATA_W-1:0] data1;
        logic [LOCK_W-1:0] lock1;
        logic [DATA_W-1:0] data2;
        logic [LOCK_W-1:0] lock2;
        logic [ROB_W-1:0]  rob;
        logic              pred;
    } entry_t;

    function automatic logic branch_taken(input op_e op, input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
        case (op)
            OP_BEQ:  return a == b;
            OP_BNE:  return a != b;
            OP_BLT:  return $signed(a) < $signed(b);
            OP_BGE:  return $signed(a) >= $signed(b);
            OP_BLTU: return a < b;
            OP_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Station state: control (valid, rank) is reset, the payload is not.
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [RANK_W-1:0] rank_q [DEPTH];
    logic [RANK_W-1:0] rank_d [DEPTH];
    entry_t            ent_q  [DEPTH];
    entry_t            ent_d  [DEPTH];

    logic              out_valid_q, out_valid_d;
    logic [ROB_W-1:0]  out_index_q, out_index_d;
    logic [1:0]        out_result_q, out_result_d;
    logic              out_mis_q, out_mis_d;

    logic [CNT_W-1:0]  occ;
    logic              free_hit;
    logic [IDX_W-1:0]  free_idx;
    logic              iss_found;
    logic [IDX_W-1:0]  iss_idx;
    logic [RANK_W-1:0] iss_rank;
    logic              out_free;
    logic              do_issue;
    logic              do_disp;
    logic              iss_taken;
    entry_t            new_ent;

    assign bra_stall = &valid_q;
    assign out_free  = !out_valid_q || rob_out_ready;
    assign do_issue  = out_free && iss_found;
    assign do_disp   = bra_enable && !bra_stall &&
                       (op_e'(bra_op) != OP_NOP) && (op_e'(bra_op) != OP_RSVD);

    // Occupancy and the lowest-numbered free slot.
    always_comb begin
        // NOTE: every variable driven here gets a default first so no latch is inferred.
        occ      = '0;
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                occ = occ + CNT_W'(1);
            end else if (!free_hit) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Oldest ready entry; woken operands become visible only after the wakeup edge.
    always_comb begin
        iss_found = 1'b0;
        iss_idx   = '0;
        iss_rank  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (ent_q[i].lock1 == '0) && (ent_q[i].lock2 == '0) &&
                (!iss_found || (rank_q[i] < iss_rank))) begin
                iss_found = 1'b1;
                iss_idx   = IDX_W'(i);
                iss_rank  = rank_q[i];
            end
        end
    end

    assign iss_taken = branch_taken(ent_q[iss_idx].op, ent_q[iss_idx].data1, ent_q[iss_idx].data2);

    always_comb begin
        new_ent.op    = op_e'(bra_op);
        new_ent.data1 = bra_data1;
        new_ent.lock1 = bra_lock1;
        new_ent.data2 = bra_data2;
        new_ent.lock2 = bra_lock2;
        new_ent.rob   = bra_rob_index;
        new_ent.pred  = bra_pred;
`ifdef BRA_DISPATCH_BYPASS_EN
        if ((cdb_in_index != '0) && (bra_lock1 == cdb_in_index)) begin
            new_ent.lock1 = '0;
            new_ent.data1 = cdb_in_result;
        end
        if ((cdb_in_index != '0) && (bra_lock2 == cdb_in_index)) begin
            new_ent.lock2 = '0;
            new_ent.data2 = cdb_in_result;
        end
`endif
    end

    always_comb begin
        valid_d      = valid_q;
        rank_d       = rank_q;
        ent_d        = ent_q;
        out_valid_d  = out_valid_q;
        out_index_d  = out_index_q;
        out_result_d = out_result_q;
        out_mis_d    = out_mis_q;

        if (flush) begin
            valid_d     = '0;
            out_valid_d = 1'b0;
            for (int i = 0; i < DEPTH; i++) rank_d[i] = '0;
        end else begin
            if (do_issue) begin
                valid_d[iss_idx] = 1'b0;
                out_valid_d      = 1'b1;
                out_index_d      = ent_q[iss_idx].rob;
                out_result_d     = {ent_q[iss_idx].pred, iss_taken};
                out_mis_d        = ent_q[iss_idx].pred ^ iss_taken;
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && (rank_q[i] > iss_rank)) rank_d[i] = rank_q[i] - RANK_W'(1);
                end
            end else if (out_free) begin
                out_valid_d = 1'b0;
            end

            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (cdb_in_index != '0)) begin
                    if (ent_q[i].lock1 == cdb_in_index) begin
                        ent_d[i].lock1 = '0;
                        ent_d[i].data1 = cdb_in_result;
                    end
                    if (ent_q[i].lock2 == cdb_in_index) begin
                        ent_d[i].lock2 = '0;
                        ent_d[i].data2 = cdb_in_result;
                    end
                end
            end

            // Ranks stay dense: an issue this cycle shrinks occupancy before the new entry lands.
            if (do_disp) begin
                valid_d[free_idx] = 1'b1;
                ent_d[free_idx]   = new_ent;
                rank_d[free_idx]  = do_issue ? RANK_W'(occ - CNT_W'(1)) : RANK_W'(occ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
        if (!rst) begin
            valid_q      <= '0;
            for (int i = 0; i < DEPTH; i++) rank_q[i] <= '0;
            out_valid_q  <= 1'b0;
            out_index_q  <= '0;
            out_result_q <= '0;
            out_mis_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rank_q       <= rank_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            out_result_q <= out_result_d;
            out_mis_q    <= out_mis_d;
        end
    end

    // NOTE: payload storage has no reset; it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign rob_out_valid      = out_valid_q;
    assign rob_out_index      = out_index_q;
    assign rob_out_result     = out_result_q;
    assign rob_out_mispredict = out_mis_q;

endmodule

// File: tb/tb_branch_rs_unit.sv
// Scoreboard bench for branch_rs_unit: an age-ordered queue model predicts results, a monitor
// compares them as the DUT presents them. Honours BRA_DISPATCH_BYPASS_EN when defined.
module tb_branch_rs_unit;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int LOCK_W = 5;
    localparam int ROB_W  = 4;
`ifdef BRA_DISPATCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              bra_enable;
    logic              bra_stall;
    logic [2:0]        bra_op;
    logic [DATA_W-1:0] bra_data1;
    logic [LOCK_W-1:0] bra_lock1;
    logic [DATA_W-1:0] bra_data2;
    logic [LOCK_W-1:0] bra_lock2;
    logic [ROB_W-1:0]  bra_rob_index;
    logic              bra_pred;
    logic [LOCK_W-1:0] cdb_in_index;
    logic [DATA_W-1:0] cdb_in_result;
    logic              flush;
    logic              rob_out_valid;
    logic              rob_out_ready;
    logic [ROB_W-1:0]  rob_out_index;
    logic [1:0]        rob_out_result;
    logic              rob_out_mispredict;

    branch_rs_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .LOCK_W(LOCK_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst),
        .bra_enable(bra_enable), .bra_stall(bra_stall), .bra_op(bra_op),
        .bra_data1(bra_data1), .bra_lock1(bra_lock1),
        .bra_data2(bra_data2), .bra_lock2(bra_lock2),
        .bra_rob_index(bra_rob_index), .bra_pred(bra_pred),
        .cdb_in_index(cdb_in_index), .cdb_in_result(cdb_in_result),
        .flush(flush),
        .rob_out_valid(rob_out_valid), .rob_out_ready(rob_out_ready),
        .rob_out_index(rob_out_index), .rob_out_result(rob_out_result),
        .rob_out_mispredict(rob_out_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]        op;
        logic [DATA_W-1:0] d1;
        logic [LOCK_W-1:0] l1;
        logic [DATA_W-1:0] d2;
        logic [LOCK_W-1:0] l2;
        logic [ROB_W-1:0]  rob;
        logic              pred;
    } ent_t;

    typedef struct {
        logic [ROB_W-1:0] rob;
        logic [1:0]       res;
        logic             mis;
    } exp_t;

    // Reference: pending branches kept in dispatch (age) order; result register as a flag.
    ent_t mdl_q[$];
    exp_t exp_q[$];
    bit   mdl_out_valid = 1'b0;
    bit   mon_en = 1'b0;

    function automatic logic ref_taken(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        case (op)
            3'd1:    return a == b;
            3'd2:    return a != b;
            3'd3:    return $signed(a) < $signed(b);
            3'd4:    return $signed(a) >= $signed(b);
            3'd5:    return a < b;
            3'd6:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_update();
        bit   full;
        bit   free;
        int   pick;
        ent_t e;
        exp_t x;
        full = (mdl_q.size() == DEPTH);
        free = !mdl_out_valid || rob_out_ready;
        if (flush) begin
            if (mdl_out_valid && !rob_out_ready && exp_q.size() > 0) void'(exp_q.pop_back());
            mdl_q.delete();
            mdl_out_valid = 1'b0;
            return;
        end
        if (free) begin
            pick = -1;
            for (int i = 0; i < mdl_q.size(); i++)
                if (pick < 0 && mdl_q[i].l1 == '0 && mdl_q[i].l2 == '0) pick = i;
            if (pick >= 0) begin
                e     = mdl_q[pick];
                x.rob = e.rob;
                x.res = {e.pred, ref_taken(e.op, e.d1, e.d2)};
                x.mis = e.pred ^ x.res[0];
                exp_q.push_back(x);
                mdl_q.delete(pick);
                mdl_out_valid = 1'b1;
            end else begin
                mdl_out_valid = 1'b0;
            end
        end
        if (cdb_in_index != '0) begin
            for (int i = 0; i < mdl_q.size(); i++) begin
                if (mdl_q[i].l1 == cdb_in_index) begin mdl_q[i].l1 = '0; mdl_q[i].d1 = cdb_in_result; end
                if (mdl_q[i].l2 == cdb_in_index) begin mdl_q[i].l2 = '0; mdl_q[i].d2 = cdb_in_result; end
            end
        end
        if (bra_enable && !full && bra_op != 3'd0 && bra_op != 3'd7) begin
            e = '{bra_op, bra_data1, bra_lock1, bra_data2, bra_lock2, bra_rob_index, bra_pred};
            if (BYPASS && cdb_in_index != '0) begin
                if (e.l1 == cdb_in_index) begin e.l1 = '0; e.d1 = cdb_in_result; end
                if (e.l2 == cdb_in_index) begin e.l2 = '0; e.d2 = cdb_in_result; end
            end
            mdl_q.push_back(e);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst && mon_en) begin
            check("stall", bra_stall, mdl_q.size() == DEPTH);
            check("out_valid", rob_out_valid, mdl_out_valid);
            if (rob_out_valid && exp_q.size() > 0) begin
                check("out_index", rob_out_index, exp_q[0].rob);
                check("out_result", rob_out_result, exp_q[0].res);
                check("out_mispredict", rob_out_mispredict, exp_q[0].mis);
                if (rob_out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic idle();
        bra_enable    = 1'b0;
        bra_op        = 3'd0;
        bra_data1     = '0;
        bra_lock1     = '0;
        bra_data2     = '0;
        bra_lock2     = '0;
        bra_rob_index = '0;
        bra_pred      = 1'b0;
        cdb_in_index  = '0;
        cdb_in_result = '0;
        flush         = 1'b0;
        rob_out_ready = 1'b1;
    endtask

    task automatic disp(input logic [2:0] op, input logic [DATA_W-1:0] d1, input logic [LOCK_W-1:0] l1,
                        input logic [DATA_W-1:0] d2, input logic [LOCK_W-1:0] l2,
                        input logic [ROB_W-1:0] rob, input logic pred);
        bra_enable    = 1'b1;
        bra_op        = op;
        bra_data1     = d1;
        bra_lock1     = l1;
        bra_data2     = d2;
        bra_lock2     = l2;
        bra_rob_index = rob;
        bra_pred      = pred;
    endtask

    // One clock: the model advances on the edge, one-shot inputs drop just after it.
    task automatic step();
        @(posedge clk);
        if (rst) model_update();
        #1;
        bra_enable   = 1'b0;
        flush        = 1'b0;
        cdb_in_index = '0;
    endtask

    task automatic mid_reset();
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", rob_out_valid, 0);
        check("mid_rst_stall", bra_stall, 0);
        check("mid_rst_index", rob_out_index, 0);
        check("mid_rst_result", rob_out_result, 0);
        mdl_q.delete();
        exp_q.delete();
        mdl_out_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        case ($urandom_range(0, 3))
            0:       return DATA_W'($urandom_range(0, 3));
            1:       return 32'h8000_0000 + DATA_W'($urandom_range(0, 2));
            2:       return 32'hFFFF_FFFF - DATA_W'($urandom_range(0, 2));
            default: return DATA_W'($urandom);
        endcase
    endfunction

    function automatic logic [LOCK_W-1:0] rnd_lock();
        return ($urandom_range(0, 1) == 0) ? '0 : LOCK_W'($urandom_range(1, 7));
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", rob_out_valid, 0);
        check("rst_index", rob_out_index, 0);
        check("rst_result", rob_out_result, 0);
        check("rst_mispredict", rob_out_mispredict, 0);
        check("rst_stall", bra_stall, 0);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Single ready BEQ: result visible after the second edge.
        disp(3'd1, 32'd5, 0, 32'd5, 0, 4'd3, 1'b0);
        step();
        step();
        check("beq_valid", rob_out_valid, 1);
        check("beq_index", rob_out_index, 3);
        check("beq_result", rob_out_result, 2'b01);
        check("beq_mispredict", rob_out_mispredict, 1);
        step();

        // Fill the station with waiting entries, then a dispatch while full is ignored.
        for (int i = 0; i < DEPTH; i++) begin
            disp(3'd1, 32'd0, 5'd7, 32'hFFFF_FFFF, 0, ROB_W'(i), 1'(i));
            step();
        end
        check("full_stall", bra_stall, 1);
        disp(3'd1, 32'd0, 0, 32'd0, 0, 4'd9, 1'b0);
        step();
        cdb_in_index  = 5'd7;
        cdb_in_result = 32'hFFFF_FFFF;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            step();
            check("wake_order", rob_out_index, ROB_W'(i));
        end
        step();
        check("after_drain_valid", rob_out_valid, 0);

        // Signed versus unsigned compares.
        disp(3'd3, 32'hFFFF_FFFF, 0, 32'd1, 0, 4'd1, 1'b0); step(); step();
        check("blt_taken", rob_out_result[0], 1);
        disp(3'd5, 32'hFFFF_FFFF, 0, 32'd1, 0, 4'd2, 1'b0); step(); step();
        check("bltu_taken", rob_out_result[0], 0);
        disp(3'd4, 32'h8000_0000, 0, 32'd0, 0, 4'd3, 1'b0); step(); step();
        check("bge_taken", rob_out_result[0], 0);
        disp(3'd6, 32'h8000_0000, 0, 32'd0, 0, 4'd4, 1'b0); step(); step();
        check("bgeu_taken", rob_out_result[0], 1);
        step();

        // Backpressure: first result held for three cycles, second follows on release.
        rob_out_ready = 1'b0;
        disp(3'd2, 32'd1, 0, 32'd2, 0, 4'd5, 1'b1); step();
        disp(3'd1, 32'd1, 0, 32'd2, 0, 4'd6, 1'b0); step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_index", rob_out_index, 5);
            check("hold_valid", rob_out_valid, 1);
        end
        rob_out_ready = 1'b1;
        step();
        check("release_index", rob_out_index, 6);
        step();

        // Flush with three waiting entries plus a dispatch in the same cycle.
        for (int i = 0; i < 3; i++) begin
            disp(3'd2, 32'd0, 5'd3, 32'd1, 0, ROB_W'(i + 1), 1'b0);
            step();
        end
        disp(3'd1, 32'd0, 0, 32'd0, 0, 4'd4, 1'b0);
        flush = 1'b1;
        step();
        check("flush_valid", rob_out_valid, 0);
        check("flush_stall", bra_stall, 0);
        cdb_in_index = 5'd3;
        step();
        check("flush_drop", rob_out_valid, 0);
        step();

        // Dispatch racing a CDB broadcast of its own tag.
        disp(3'd1, 32'h10, 0, 32'd0, 5'd9, 4'd7, 1'b1);
        cdb_in_index  = 5'd9;
        cdb_in_result = 32'h10;
        step();
        step();
        check("bypass_issue", rob_out_valid, BYPASS);
        step();
        flush = 1'b1;
        step();
        step();

        // Randomised traffic with a mid-run asynchronous reset.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc == 700) mid_reset();
            bra_enable    = ($urandom_range(0, 3) != 0);
            bra_op        = 3'($urandom_range(0, 7));
            bra_data1     = rnd_data();
            bra_lock1     = rnd_lock();
            bra_data2     = rnd_data();
            bra_lock2     = rnd_lock();
            bra_rob_index = ROB_W'($urandom_range(0, 15));
            bra_pred      = 1'($urandom_range(0, 1));
            cdb_in_index  = ($urandom_range(0, 1) == 0) ? '0 : LOCK_W'($urandom_range(1, 7));
            cdb_in_result = rnd_data();
            if (!BYPASS && bra_enable && cdb_in_index != '0 &&
                (bra_lock1 == cdb_in_index || bra_lock2 == cdb_in_index)) cdb_in_index = '0;
            flush         = ($urandom_range(0, 31) == 0);
            rob_out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain: broadcast every tag in use, then let everything issue.
        idle();
        for (int t = 1; t <= 7; t++) begin
            cdb_in_index  = LOCK_W'(t);
            cdb_in_result = DATA_W'($urandom);
            step();
        end
        repeat (12) step();
        check("drain_valid", rob_out_valid, 0);
        check("drain_stall", bra_stall, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
